meas_ascii_fmt: RTL and testbench

Converts one signed millivolt measurement sample into a fixed 8-character ASCII record, for example "+1.234V\n". It then hands the record to the UART transmitter through that transmitter's char-array/update/busy interface. It sits directly upstream of the UART stage: it sits between the measurement/averaging path and uart_top, with char_array_o feeding char_array_i, char_array_update_o feeding char_array_update_i, and uart_top busy_o returned on uart_busy_i. Binary-to-decimal conversion is sequential (shift-add-3), so the block has a fixed latency and drops samples that arrive while it is busy.

---
 rtl/meas_ascii_fmt.sv | 200 ++++++++++++++++++++
 tb/tb_meas_ascii_fmt.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/meas_ascii_fmt.sv
// -----------------------------------------------------------------------------
// meas_ascii_fmt
//
// Turns one signed millivolt sample into a fixed 8-character ASCII record such
// as "+1.234V\n" and hands it to the UART transmitter through its
// char-array / update / busy handshake. Magnitudes above MAX_MAG print as
// "OVERLD\r\n". The binary-to-BCD conversion is sequential (shift-add-3, one
// bit per cycle, 14 cycles), so the latency is fixed. Samples that arrive while
// the block is busy are rejected and counted.
//
// Ports
//   clk                 system clock
//   rst                 synchronous active-high reset, highest priority
//   sample_i            signed two's-complement measurement in mV
//   sample_valid_i      one-cycle qualifier for sample_i
//   clr_i               synchronous abort; also clears the drop counter
//   uart_busy_i         UART transfer busy, sampled only while waiting to send
//   char_array_o        record; char 0 in the top byte, transmitted first
//   char_array_update_o one-cycle pulse: record valid, start transfer
//   fmt_busy_o          high whenever the block is not idle
//   drop_cnt_o          saturating count of rejected samples
// -----------------------------------------------------------------------------
module meas_ascii_fmt #(
    parameter int         VAL_W     = 16,
    parameter int         CHAR_NR   = 8,
    parameter logic [7:0] UNIT_CHAR = 8'h56,
    parameter int         MAX_MAG   = 9999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VAL_W-1:0]     sample_i,
    input  logic                 sample_valid_i,
    input  logic                 clr_i,
    input  logic                 uart_busy_i,
    output logic [CHAR_NR*8-1:0] char_array_o,
    output logic                 char_array_update_o,
    output logic                 fmt_busy_o,
    output logic [7:0]           drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONV    = 2'd1,
        WAIT_TX = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        step_cnt;
    logic              sign;
    logic              ovl;
    logic [13:0]       mag_sh;
    logic [15:0]       bcd;
    logic [15:0]       bcd_next;
    logic [VAL_W:0]    mag_abs;
    logic [VAL_W:0]    sample_ext;
    logic              accept;
    logic              last_step;

    // One shift-add-3 step: correct every digit >= 5, then shift in one bit.
    function automatic logic [15:0] bcd_step(input logic [15:0] bcd_in,
                                             input logic        bit_in);
        logic [15:0] adj;
        adj = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd_in[4*i +: 4];
            end
        end
        return {adj[14:0], bit_in};
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // The layout is fixed at 8 characters, hence the 64-bit record.
    function automatic logic [63:0] make_record(input logic        neg,
                                                input logic        over,
                                                input logic [15:0] digits);
        if (over) begin
            return {8'h4F, 8'h56, 8'h45, 8'h52, 8'h4C, 8'h44, 8'h0D, 8'h0A};
        end else begin
            return {(neg ? 8'h2D : 8'h2B),
                    ascii_digit(digits[15:12]), 8'h2E,
                    ascii_digit(digits[11:8]),
                    ascii_digit(digits[7:4]),
                    ascii_digit(digits[3:0]),
                    UNIT_CHAR, 8'h0A};
        end
    endfunction

    // Magnitude in VAL_W+1 bits so the most negative sample stays representable.
    always_comb begin
        sample_ext = {sample_i[VAL_W-1], sample_i};
        mag_abs    = sample_ext;
        if (sample_i[VAL_W-1]) begin
            mag_abs = (~sample_ext) + {{VAL_W{1'b0}}, 1'b1};
        end else begin
            mag_abs = sample_ext;
        end
    end

    // Handshake qualifiers and the BCD value after the current step.
    always_comb begin
        accept    = (state == IDLE) && sample_valid_i && !clr_i;
        last_step = (state == CONV) && (step_cnt == 4'd13);
        bcd_next  = bcd_step(bcd, mag_sh[13]);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; clr_i aborts from any state.
    always_comb begin
        state_next = state;
        if (clr_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = sample_valid_i ? CONV : IDLE;
                CONV:    state_next = (step_cnt == 4'd13) ? WAIT_TX : CONV;
                WAIT_TX: state_next = uart_busy_i ? WAIT_TX : SEND;
                SEND:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Sample capture and the bit-serial conversion datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign     <= 1'b0;
            ovl      <= 1'b0;
            mag_sh   <= 14'd0;
            bcd      <= 16'd0;
            step_cnt <= 4'd0;
        end else if (accept) begin
            sign     <= sample_i[VAL_W-1];
            ovl      <= (mag_abs > (VAL_W+1)'(MAX_MAG));
            mag_sh   <= mag_abs[13:0];
            bcd      <= 16'd0;
            step_cnt <= 4'd0;
        end else if ((state == CONV) && !clr_i) begin
            mag_sh   <= {mag_sh[12:0], 1'b0};
            bcd      <= bcd_next;
            step_cnt <= step_cnt + 4'd1;
        end else begin
            mag_sh   <= mag_sh;
            bcd      <= bcd;
            step_cnt <= step_cnt;
        end
    end

    // Record register: loaded only on the last conversion step, using the
    // digits that step produces, so it is stable from WAIT_TX onward.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_array_o <= '0;
        end else if (last_step && !clr_i) begin
            char_array_o <= make_record(sign, ovl, bcd_next);
        end else begin
            char_array_o <= char_array_o;
        end
    end

    // Status outputs registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_array_update_o <= 1'b0;
            fmt_busy_o          <= 1'b0;
        end else begin
            char_array_update_o <= (state_next == SEND);
            fmt_busy_o          <= (state_next != IDLE);
        end
    end

    // Saturating counter of samples rejected because the block was busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_o <= 8'd0;
        end else if (clr_i) begin
            drop_cnt_o <= 8'd0;
        end else if (sample_valid_i && (state != IDLE) && (drop_cnt_o != 8'hFF)) begin
            drop_cnt_o <= drop_cnt_o + 8'd1;
        end else begin
            drop_cnt_o <= drop_cnt_o;
        end
    end

endmodule

// File: tb/tb_meas_ascii_fmt.sv
// -----------------------------------------------------------------------------
// tb_meas_ascii_fmt
//
// Self-checking bench for meas_ascii_fmt. Expected records come from plain
// decimal arithmetic on the sample value; expected timing is computed from the
// cycle in which the sample was offered and the cycle uart_busy_i falls.
// -----------------------------------------------------------------------------
module tb_meas_ascii_fmt;

    logic        clk;
    logic        rst;
    logic [15:0] sample_i;
    logic        sample_valid_i;
    logic        clr_i;
    logic        uart_busy_i;
    logic [63:0] char_array_o;
    logic        char_array_update_o;
    logic        fmt_busy_o;
    logic [7:0]  drop_cnt_o;

    int          vec_cnt;
    int          err_cnt;
    logic [63:0] last_rec;
    int          exp_drop;

    meas_ascii_fmt dut (
        .clk                 (clk),
        .rst                 (rst),
        .sample_i            (sample_i),
        .sample_valid_i      (sample_valid_i),
        .clr_i               (clr_i),
        .uart_busy_i         (uart_busy_i),
        .char_array_o        (char_array_o),
        .char_array_update_o (char_array_update_o),
        .fmt_busy_o          (fmt_busy_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference record from decimal arithmetic.
    function automatic logic [63:0] exp_rec(input int v);
        int a;
        a = (v < 0) ? -v : v;
        if (a > 9999) begin
            return {8'h4F, 8'h56, 8'h45, 8'h52, 8'h4C, 8'h44, 8'h0D, 8'h0A};
        end
        return {(v < 0) ? 8'h2D : 8'h2B,
                8'(48 + a / 1000), 8'h2E,
                8'(48 + (a / 100) % 10),
                8'(48 + (a / 10) % 10),
                8'(48 + a % 10),
                8'h56, 8'h0A};
    endfunction

    // Offer v in the current cycle (c=0); uart_busy_i is high until cycle
    // m = 15 + extra. Rejected samples are pulsed at c = 1 + i*stride for
    // i < ndrop, and optionally during the send cycle.
    task automatic run_tx(input int v, input int extra, input int ndrop,
                          input int stride, input bit send_drop);
        int          m;
        logic [63:0] rec;
        m   = 15 + extra;
        rec = exp_rec(v);
        sample_i       = 16'(v);
        sample_valid_i = 1'b1;
        uart_busy_i    = 1'b1;
        for (int c = 1; c <= m + 2; c++) begin
            tick();
            uart_busy_i    = (c < m);
            sample_valid_i = 1'b0;
            if (c <= m + 1 &&
                ((((c - 1) % stride) == 0 && ((c - 1) / stride) < ndrop) ||
                 (send_drop && c == m + 1))) begin
                sample_valid_i = 1'b1;
                sample_i       = 16'($urandom);
                if (exp_drop < 255) exp_drop++;
            end
            chk("fmt_busy", 64'(fmt_busy_o), 64'(c <= m + 1));
            chk("update", 64'(char_array_update_o), 64'(c == m + 1));
            chk("char_array", char_array_o, (c <= 14) ? last_rec : rec);
            if (c == m + 2) chk("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
        end
        sample_valid_i = 1'b0;
        last_rec = rec;
    endtask

    // Offer v, then abort with clr_i or rst in cycle ac; no pulse may follow.
    task automatic abort_run(input int v, input int ac, input bit use_rst);
        sample_i       = 16'(v);
        sample_valid_i = 1'b1;
        uart_busy_i    = 1'b1;
        for (int c = 1; c <= ac; c++) begin
            tick();
            sample_valid_i = 1'b0;
            chk("abort_busy", 64'(fmt_busy_o), 64'd1);
            chk("abort_char", char_array_o, (c >= 15) ? exp_rec(v) : last_rec);
        end
        if (ac >= 15) last_rec = exp_rec(v);
        if (use_rst) rst = 1'b1;
        else         clr_i = 1'b1;
        tick();
        rst   = 1'b0;
        clr_i = 1'b0;
        uart_busy_i = 1'b0;
        exp_drop = 0;
        if (use_rst) last_rec = 64'd0;
        chk("abort_fmt_busy", 64'(fmt_busy_o), 64'd0);
        chk("abort_update", 64'(char_array_update_o), 64'd0);
        chk("abort_drop", 64'(drop_cnt_o), 64'd0);
        chk("abort_char_after", char_array_o, last_rec);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("abort_no_pulse", 64'(char_array_update_o), 64'd0);
            chk("abort_idle", 64'(fmt_busy_o), 64'd0);
        end
    endtask

    initial begin
        int               v;
        logic signed [15:0] r16;
        vec_cnt        = 0;
        err_cnt        = 0;
        exp_drop       = 0;
        last_rec       = 64'd0;
        rst            = 1'b1;
        sample_i       = 16'd0;
        sample_valid_i = 1'b0;
        clr_i          = 1'b0;
        uart_busy_i    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_char", char_array_o, 64'd0);
        chk("rst_update", 64'(char_array_update_o), 64'd0);
        chk("rst_busy", 64'(fmt_busy_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        tick();

        // Directed values, minimum latency, back-to-back accepts.
        run_tx(1234, 0, 0, 1, 1'b0);
        chk("rec_1234", char_array_o, 64'h2B312E3233345600 | 64'h0A);
        run_tx(-5, 0, 0, 1, 1'b0);
        chk("rec_m5", char_array_o, 64'h2D302E303035560A);
        run_tx(0, 0, 0, 1, 1'b0);
        run_tx(9999, 0, 0, 1, 1'b0);
        run_tx(-9999, 0, 0, 1, 1'b0);
        run_tx(10000, 0, 0, 1, 1'b0);
        chk("rec_ovl", char_array_o, 64'h4F5645524C440D0A);
        run_tx(-10000, 0, 0, 1, 1'b0);
        run_tx(-32768, 0, 0, 1, 1'b0);
        run_tx(32767, 0, 0, 1, 1'b0);

        // UART busy for 200 cycles with three rejected samples meanwhile.
        run_tx(4321, 200, 3, 60, 1'b0);

        // Randomized values, busy durations and rejected samples.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 9999));
                1: v = -int'($urandom_range(0, 9999));
                2: v = int'($urandom_range(9995, 10005)) * (($urandom_range(0, 1) == 0) ? 1 : -1);
                default: begin
                    r16 = 16'($urandom);
                    v   = int'(r16);
                end
            endcase
            run_tx(v, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 5,
                   1'($urandom_range(0, 1)));
        end

        // 300 rejected samples saturate the counter.
        run_tx(777, 300, 300, 1, 1'b0);
        chk("drop_sat", 64'(drop_cnt_o), 64'd255);

        // clr_i beats a simultaneous sample in IDLE.
        clr_i          = 1'b1;
        sample_valid_i = 1'b1;
        sample_i       = 16'd100;
        tick();
        clr_i          = 1'b0;
        sample_valid_i = 1'b0;
        exp_drop       = 0;
        chk("clr_drop", 64'(drop_cnt_o), 64'd0);
        for (int c = 0; c < 20; c++) begin
            chk("clr_no_busy", 64'(fmt_busy_o), 64'd0);
            chk("clr_no_pulse", 64'(char_array_update_o), 64'd0);
            tick();
        end

        // Aborts: clr_i mid-conversion, clr_i while waiting, rst mid-conversion.
        abort_run(2468, 5, 1'b0);
        abort_run(-1357, 20, 1'b0);
        abort_run(8642, 7, 1'b1);

        // Normal operation resumes after the reset.
        run_tx(-1234, 2, 0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
